// File: rtl/md_unit_ctrl.sv
// ---------------------------------------------------------------------------
// md_unit_ctrl
// Sequencer for the multicycle multiply/divide resource beside the EX-stage
// ALU. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX. A multiply or divide
// opens a fixed-length busy window and commits HI/LO at its end. MTHI and
// MTLO write straight into HI/LO. Raises a stall request for the hazard unit
// while an md-class instruction in D would collide with an operation in flight.
//
// Optional feature macro: MD_CANCEL_EN
//   When defined, cancel aborts an operation in flight and suppresses a start
//   in the same cycle. When undefined, cancel is ignored.
//
// Parameters
//   MULT_CYCLES  busy cycles for MULT/MULTU (1..63)
//   DIV_CYCLES   busy cycles for DIV/DIVU   (1..63)
// Ports
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-high reset
//   start     in   EX holds a valid md instruction
//   md_op     in   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   md_a      in   forwarded RS value
//   md_b      in   forwarded RT value
//   md_use_D  in   D-stage instruction is md-class
//   cancel    in   abort request from exception logic
//   HI, LO    out  architectural HI/LO
//   busy      out  operation in flight
//   stall_md  out  stall request to hazard unit
// ---------------------------------------------------------------------------
module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] md_a,
  input  logic [31:0] md_b,
  input  logic        md_use_D,
  input  logic        cancel,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy,
  output logic        stall_md
);

  localparam logic [5:0] MULT_CNT = 6'(MULT_CYCLES);
  localparam logic [5:0] DIV_CNT  = 6'(DIV_CYCLES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q;
  logic [5:0]  cnt_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] hi_tmp_q, lo_tmp_q;
  logic        commit_q;   // cleared for divide by zero: window runs, no write

  logic        cancel_eff;
`ifdef MD_CANCEL_EN
  assign cancel_eff = cancel;
`else
  logic unused_cancel;
  assign unused_cancel = cancel;
  assign cancel_eff    = 1'b0;
`endif

  // Arithmetic on the operands presented in the start cycle
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        div_b, quo_s, rem_s, quo_u, rem_u;
  logic               b_zero, div_ovf;
  logic [31:0]        res_hi, res_lo;

  assign b_zero  = (md_b == 32'd0);
  assign div_ovf = (md_a == 32'h8000_0000) && (md_b == 32'hFFFF_FFFF);
  // Substitute a harmless divisor for the zero and overflow cases so the
  // divider never sees them; those results are overridden or discarded.
  assign div_b   = (b_zero || div_ovf) ? 32'd1 : md_b;

  assign prod_s = $signed({{32{md_a[31]}}, md_a}) * $signed({{32{md_b[31]}}, md_b});
  assign prod_u = {32'd0, md_a} * {32'd0, md_b};
  assign quo_s  = div_ovf ? 32'h8000_0000 : 32'($signed(md_a) / $signed(div_b));
  assign rem_s  = div_ovf ? 32'd0         : 32'($signed(md_a) % $signed(div_b));
  assign quo_u  = md_a / div_b;
  assign rem_u  = md_a % div_b;

  always_comb begin
    res_hi = prod_s[63:32];
    res_lo = prod_s[31:0];
    case (md_op[1:0])
      2'd1: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
      2'd2: begin res_hi = rem_s;         res_lo = quo_s;        end
      2'd3: begin res_hi = rem_u;         res_lo = quo_u;        end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      hi_tmp_q <= '0;
      lo_tmp_q <= '0;
      commit_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !cancel_eff) begin
            if (md_op <= 3'd3) begin
              hi_tmp_q <= res_hi;
              lo_tmp_q <= res_lo;
              commit_q <= !(md_op[1] && b_zero);
              cnt_q    <= md_op[1] ? DIV_CNT : MULT_CNT;
              state_q  <= RUN;
            end else if (md_op == 3'd4) begin
              hi_q <= md_a;
            end else if (md_op == 3'd5) begin
              lo_q <= md_a;
            end
          end
        end
        RUN: begin
          // start is never honoured here; the temp result stays as latched
          if (cancel_eff) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 6'd1;
            if (cnt_q == 6'd1) begin
              state_q <= IDLE;
              if (commit_q) begin
                hi_q <= hi_tmp_q;
                lo_q <= lo_tmp_q;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign HI       = hi_q;
  assign LO       = lo_q;
  assign busy     = (state_q == RUN);
  assign stall_md = md_use_D & (busy | start);

endmodule
